// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for a bank of PWM channels: programs period/duty/enable over the
// register bus, then ramps duty toward a target in timed steps.
module pwm_fade_ctrl #(
    parameter int NCH       = 8,
    parameter int CH_STRIDE = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_ch,
    input  logic [31:0] cmd_period,
    input  logic [31:0] cmd_start,
    input  logic [31:0] cmd_target,
    input  logic [15:0] cmd_step,
    input  logic [23:0] cmd_interval,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        pwm_wr,
    output logic        pwm_rd,
    output logic [6:0]  pwm_adrs,
    output logic [31:0] pwm_din
);

    // state     | meaning
    // ----------+-----------------------------------------------
    // IDLE      | ready for a command
    // WR_PER    | bus write of period
    // WR_DUTY   | bus write of starting duty
    // WR_EN     | bus write of enable = 1
    // WAIT      | interval timer running, bus quiet
    // STEP      | bus write of next duty toward target
    // STOP      | bus write of enable = 0 after abort
    // DONE      | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PER,
        S_WR_DUTY,
        S_WR_EN,
        S_WAIT,
        S_STEP,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [31:0] NCH_U   = 32'(NCH);
    localparam logic [6:0]  OFS_EN  = 7'd0;
    localparam logic [6:0]  OFS_PER = 7'd4;
    localparam logic [6:0]  OFS_DTY = 7'd8;

    state_t      state, state_nxt;
    logic [2:0]  ch_q;
    logic [31:0] period_q;
    logic [31:0] cur_q;
    logic [31:0] target_q;
    logic [15:0] step_q;
    logic [23:0] interval_q;
    logic [23:0] wait_cnt;

    logic        accept;
    logic        ch_bad;
    logic [31:0] start_clamp;
    logic [31:0] target_clamp;
    logic [31:0] step_ext;
    logic [31:0] duty_nxt;
    logic [23:0] wait_load;
    logic [6:0]  base_adrs;

    assign accept       = cmd_valid && (state == S_IDLE);
    assign ch_bad       = 32'(cmd_ch) >= NCH_U;
    assign start_clamp  = (cmd_start  > cmd_period) ? cmd_period : cmd_start;
    assign target_clamp = (cmd_target > cmd_period) ? cmd_period : cmd_target;
    assign step_ext     = {16'd0, step_q};
    assign wait_load    = (interval_q == 24'd0) ? 24'd1 : interval_q;
    assign base_adrs    = 7'(ch_q * CH_STRIDE);

    // Distance is compared before adding/subtracting so neither direction can wrap.
    always_comb begin
        duty_nxt = target_q;
        if (step_q != 16'd0 && cur_q != target_q) begin
            if (cur_q < target_q) begin
                if ((target_q - cur_q) > step_ext) begin
                    duty_nxt = cur_q + step_ext;
                end
            end else begin
                if ((cur_q - target_q) > step_ext) begin
                    duty_nxt = cur_q - step_ext;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = ch_bad ? S_DONE : S_WR_PER;
                end
            end
            S_WR_PER:  state_nxt = abort ? S_STOP : S_WR_DUTY;
            S_WR_DUTY: state_nxt = abort ? S_STOP : S_WR_EN;
            S_WR_EN: begin
                if (abort) begin
                    state_nxt = S_STOP;
                end else begin
                    state_nxt = (cur_q == target_q) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_STOP;
                end else if (wait_cnt == 24'd1) begin
                    state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                if (abort) begin
                    state_nxt = S_STOP;
                end else begin
                    state_nxt = (duty_nxt == target_q) ? S_DONE : S_WAIT;
                end
            end
            S_STOP:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Out-of-range channels are swallowed without touching the channel context.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q       <= 3'd0;
            period_q   <= 32'd0;
            cur_q      <= 32'd0;
            target_q   <= 32'd0;
            step_q     <= 16'd0;
            interval_q <= 24'd0;
        end else if (accept && !ch_bad) begin
            ch_q       <= cmd_ch;
            period_q   <= cmd_period;
            cur_q      <= start_clamp;
            target_q   <= target_clamp;
            step_q     <= cmd_step;
            interval_q <= cmd_interval;
        end else if (state == S_STEP) begin
            cur_q      <= duty_nxt;
        end
    end

    // Down-counter reloaded whenever the FSM is outside WAIT; WAIT exits at terminal count 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 24'd0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 24'd1;
        end else begin
            wait_cnt <= wait_load;
        end
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        pwm_rd    = 1'b0;
        pwm_wr    = 1'b0;
        pwm_adrs  = 7'd0;
        pwm_din   = 32'd0;
        case (state)
            S_WR_PER: begin
                pwm_wr   = 1'b1;
                pwm_adrs = base_adrs + OFS_PER;
                pwm_din  = period_q;
            end
            S_WR_DUTY: begin
                pwm_wr   = 1'b1;
                pwm_adrs = base_adrs + OFS_DTY;
                pwm_din  = cur_q;
            end
            S_WR_EN: begin
                pwm_wr   = 1'b1;
                pwm_adrs = base_adrs + OFS_EN;
                pwm_din  = 32'd1;
            end
            S_STEP: begin
                pwm_wr   = 1'b1;
                pwm_adrs = base_adrs + OFS_DTY;
                pwm_din  = duty_nxt;
            end
            S_STOP: begin
                pwm_wr   = 1'b1;
                pwm_adrs = base_adrs + OFS_EN;
                pwm_din  = 32'd0;
            end
            default: begin
                pwm_wr   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: logs every bus write with its cycle number and
// compares against hand-computed write lists and done timing.
module tb_pwm_fade_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_ch = 3'd0;
    logic [31:0] cmd_period = 32'd0;
    logic [31:0] cmd_start = 32'd0;
    logic [31:0] cmd_target = 32'd0;
    logic [15:0] cmd_step = 16'd0;
    logic [23:0] cmd_interval = 24'd0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        pwm_wr;
    logic        pwm_rd;
    logic [6:0]  pwm_adrs;
    logic [31:0] pwm_din;

    pwm_fade_ctrl #(.NCH(8), .CH_STRIDE(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ch       (cmd_ch),
        .cmd_period   (cmd_period),
        .cmd_start    (cmd_start),
        .cmd_target   (cmd_target),
        .cmd_step     (cmd_step),
        .cmd_interval (cmd_interval),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .pwm_wr       (pwm_wr),
        .pwm_rd       (pwm_rd),
        .pwm_adrs     (pwm_adrs),
        .pwm_din      (pwm_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int idle_bad = 0;
    int n_acc = 0;

    int          w_cyc[$];
    logic [31:0] w_adr[$];
    logic [31:0] w_din[$];
    int          e_cyc[$];
    logic [31:0] e_adr[$];
    logic [31:0] e_din[$];

    always @(posedge clk) begin
        cyc++;
        if (cmd_valid && cmd_ready) n_acc++;
    end

    always @(negedge clk) begin
        if (pwm_wr) begin
            w_cyc.push_back(cyc);
            w_adr.push_back(32'(pwm_adrs));
            w_din.push_back(pwm_din);
        end else if (pwm_adrs != 7'd0 || pwm_din != 32'd0) begin
            idle_bad++;
        end
        if (pwm_rd) idle_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic expect_wr(input int c, input logic [31:0] a, input logic [31:0] d);
        e_cyc.push_back(c);
        e_adr.push_back(a);
        e_din.push_back(d);
    endtask

    task automatic cmp_writes(input string tag);
        int n;
        chk($sformatf("%s_nwr", tag), 32'(w_cyc.size()), 32'(e_cyc.size()));
        n = (w_cyc.size() < e_cyc.size()) ? w_cyc.size() : e_cyc.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_w%0d_adr", tag, i), w_adr[i], e_adr[i]);
            chk($sformatf("%s_w%0d_din", tag, i), w_din[i], e_din[i]);
            chk($sformatf("%s_w%0d_cyc", tag, i), 32'(w_cyc[i]), 32'(e_cyc[i]));
        end
        w_cyc.delete(); w_adr.delete(); w_din.delete();
        e_cyc.delete(); e_adr.delete(); e_din.delete();
    endtask

    task automatic send(input logic [2:0] ch, input logic [31:0] per, input logic [31:0] st,
                        input logic [31:0] tg, input logic [15:0] stp, input logic [23:0] iv,
                        input bit hold, output int acc);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_ch = ch; cmd_period = per; cmd_start = st; cmd_target = tg;
        cmd_step = stp; cmd_interval = iv; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dc);
        bit seen;
        seen = 1'b0;
        dc = -1;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dc = cyc;
            end
        end
        if (!seen) chk($sformatf("%s_done_timeout", tag), 32'd0, 32'd1);
    endtask

    task automatic goto_cyc(input int c);
        for (int k = 0; k < 200 && cyc != c; k++) @(negedge clk);
    endtask

    int acc, acc2, dc, rel;

    initial begin
        // reset values while rst is held low
        #12;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_wr",    32'(pwm_wr),    32'd0);
        chk("rst_adrs",  32'(pwm_adrs),  32'd0);
        chk("rst_din",   pwm_din,        32'd0);
        @(negedge clk);
        rst = 1'b1;

        // up ramp on ch0
        send(3'd0, 32'd20, 32'd2, 32'd8, 16'd2, 24'd3, 1'b0, acc);
        expect_wr(acc,      32'h04, 32'd20);
        expect_wr(acc + 1,  32'h08, 32'd2);
        expect_wr(acc + 2,  32'h00, 32'd1);
        expect_wr(acc + 6,  32'h08, 32'd4);
        expect_wr(acc + 10, 32'h08, 32'd6);
        expect_wr(acc + 14, 32'h08, 32'd8);
        wait_done("t1", dc);
        chk("t1_done_cyc", 32'(dc), 32'(acc + 15));
        @(negedge clk);
        chk("t1_done_width", 32'(done), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        cmp_writes("t1");

        // down ramp on ch7 with saturation, interval 0 behaves as 1
        send(3'd7, 32'd20, 32'd18, 32'd5, 16'd4, 24'd0, 1'b0, acc);
        expect_wr(acc,      32'h58, 32'd20);
        expect_wr(acc + 1,  32'h5c, 32'd18);
        expect_wr(acc + 2,  32'h54, 32'd1);
        expect_wr(acc + 4,  32'h5c, 32'd14);
        expect_wr(acc + 6,  32'h5c, 32'd10);
        expect_wr(acc + 8,  32'h5c, 32'd6);
        expect_wr(acc + 10, 32'h5c, 32'd5);
        wait_done("t2", dc);
        chk("t2_done_cyc", 32'(dc), 32'(acc + 11));
        @(negedge clk);
        cmp_writes("t2");

        // start and target clamped to period; no STEP
        send(3'd2, 32'd20, 32'd30, 32'd40, 16'd1, 24'd5, 1'b0, acc);
        expect_wr(acc,     32'h1c, 32'd20);
        expect_wr(acc + 1, 32'h20, 32'd20);
        expect_wr(acc + 2, 32'h18, 32'd1);
        wait_done("t3", dc);
        chk("t3_done_cyc", 32'(dc), 32'(acc + 3));
        @(negedge clk);
        cmp_writes("t3");

        // abort during WAIT on ch1
        send(3'd1, 32'd100, 32'd10, 32'd50, 16'd5, 24'd10, 1'b0, acc);
        expect_wr(acc,     32'h10, 32'd100);
        expect_wr(acc + 1, 32'h14, 32'd10);
        expect_wr(acc + 2, 32'h0c, 32'd1);
        expect_wr(acc + 6, 32'h0c, 32'd0);
        goto_cyc(acc + 5);
        abort = 1'b1;
        wait_done("t4", dc);
        abort = 1'b0;
        chk("t4_done_cyc", 32'(dc), 32'(acc + 7));
        @(negedge clk);
        chk("t4_busy_after", 32'(busy), 32'd0);
        cmp_writes("t4");

        // cmd_valid held through a fade; step 0 jumps to target
        n_acc = 0;
        send(3'd0, 32'd50, 32'd0, 32'd30, 16'd0, 24'd2, 1'b1, acc);
        expect_wr(acc,      32'h04, 32'd50);
        expect_wr(acc + 1,  32'h08, 32'd0);
        expect_wr(acc + 2,  32'h00, 32'd1);
        expect_wr(acc + 5,  32'h08, 32'd30);
        expect_wr(acc + 8,  32'h04, 32'd50);
        expect_wr(acc + 9,  32'h08, 32'd0);
        expect_wr(acc + 10, 32'h00, 32'd1);
        expect_wr(acc + 13, 32'h08, 32'd30);
        wait_done("t5a", dc);
        chk("t5_done1_cyc", 32'(dc), 32'(acc + 6));
        goto_cyc(acc + 8);
        cmd_valid = 1'b0;
        chk("t5_accepts", 32'(n_acc), 32'd2);
        wait_done("t5b", dc);
        chk("t5_done2_cyc", 32'(dc), 32'(acc + 14));
        @(negedge clk);
        cmp_writes("t5");

        // async reset mid-WAIT, then a command on the first edge after release
        send(3'd3, 32'd40, 32'd0, 32'd40, 16'd1, 24'd20, 1'b0, acc);
        expect_wr(acc,     32'h28, 32'd40);
        expect_wr(acc + 1, 32'h2c, 32'd0);
        expect_wr(acc + 2, 32'h24, 32'd1);
        goto_cyc(acc + 6);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy",  32'(busy),     32'd0);
        chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
        chk("t6_rst_wr",    32'(pwm_wr),   32'd0);
        chk("t6_rst_adrs",  32'(pwm_adrs), 32'd0);
        chk("t6_rst_din",   pwm_din,       32'd0);
        chk("t6_rst_done",  32'(done),     32'd0);
        repeat (3) @(negedge clk);
        cmp_writes("t6a");
        rel = cyc;
        rst = 1'b1;
        cmd_ch = 3'd4; cmd_period = 32'd10; cmd_start = 32'd10; cmd_target = 32'd10;
        cmd_step = 16'd1; cmd_interval = 24'd1; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        acc2 = cyc;
        cmd_valid = 1'b0;
        expect_wr(rel + 1, 32'h34, 32'd10);
        expect_wr(rel + 2, 32'h38, 32'd10);
        expect_wr(rel + 3, 32'h30, 32'd1);
        wait_done("t6b", dc);
        chk("t6_done_cyc", 32'(dc), 32'(acc2 + 3));
        @(negedge clk);
        cmp_writes("t6b");

        chk("idle_bus_clean", 32'(idle_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter NCH, default 8: number of pwm channels addressable (channel index 0..NCH-1).
REQ-002 Parameter CH_STRIDE, default 12: byte distance between channel register groups; enable at base+0, period at base+4, duty at base+8, base = ch*CH_STRIDE.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready both 1 on a clk edge.
REQ-007 cmd_ch  input  3  target channel.
REQ-008 cmd_period  input  32  period value written to channel.
REQ-009 cmd_start / cmd_target  input  32 each  initial and final duty.
REQ-010 cmd_step  input  16  duty increment per step (unsigned).
REQ-011 cmd_interval  input  24  clk cycles between steps.
REQ-012 abort  input  1  level; terminates active fade.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at fade completion or abort completion.
REQ-015 pwm_wr  output  1  write strobe to pwm register bus; pwm_rd output 1, held 0.
REQ-016 pwm_adrs  output  7  register byte address; pwm_din output 32 write data.

Function
REQ-017 States: IDLE, WR_PER, WR_DUTY, WR_EN, WAIT, STEP, STOP, DONE.
REQ-018 cmd_ready = 1 only in IDLE; all cmd_* fields registered on acceptance; inputs ignored otherwise.
REQ-019 Command with cmd_ch >= NCH is accepted and discarded: IDLE -> DONE, no bus write.
REQ-020 cmd_start and cmd_target above cmd_period are clamped to cmd_period at acceptance.
REQ-021 Acceptance at edge T: cycles T+1, T+2, T+3 are single-cycle writes (pwm_wr=1) of period, duty=start, enable=1 to the channel's addresses, states WR_PER, WR_DUTY, WR_EN.
REQ-022 After WR_EN: if cur_duty == target -> DONE; else WAIT.
REQ-023 WAIT holds pwm_wr=0 for max(cmd_interval,1) cycles, then STEP.
REQ-024 STEP is one write cycle of duty: cur moves toward target by cmd_step, saturating at target (no overshoot, no 32-bit wrap for up or down ramps); cmd_step = 0 jumps directly to target.
REQ-025 After STEP: cur == target -> DONE, else WAIT.
REQ-026 DONE lasts one cycle with done=1, then IDLE.
REQ-027 abort=1 sampled in WAIT, STEP, WR_DUTY or WR_EN -> STOP instead of the normal next state; STOP writes enable=0 (one cycle), then DONE; abort in WR_PER goes to STOP the same way; abort in IDLE/DONE ignored.
REQ-028 Outside write cycles pwm_wr=0, pwm_adrs and pwm_din hold 0.
REQ-029 Exactly one bus write per write state; no back-to-back duplicate writes.

Reset
REQ-030 rst=0 forces, asynchronously, state IDLE, cmd_ready=1, busy=0, done=0, pwm_wr=0, pwm_rd=0, pwm_adrs=0, pwm_din=0, internal counters and registers 0.
REQ-031 Reset mid-fade abandons the fade with no further writes; the pwm channel keeps its last written values (no stop write issued).
REQ-032 After rst release, first command acceptable on the first clk edge with rst=1.

Verification
REQ-033 ch=0, period=20, start=2, target=8, step=2, interval=3 -> writes (0x04,20),(0x08,2),(0x00,1), then 3 duty writes to 0x08 of 4,6,8 spaced 4 cycles apart, done one cycle after last write.
REQ-034 ch=7, period=20, start=18, target=5, step=4 -> duty writes to 0x5c of 18,14,10,6,5 (saturation), enable at 0x54.
REQ-035 start=30, target=40, period=20 -> both clamped to 20; WR_EN followed directly by DONE, no STEP.
REQ-036 abort raised during WAIT of ch=1 fade -> single write (0x0c,0), done pulse, busy low next cycle.
REQ-037 cmd_valid held during a fade -> no second acceptance until IDLE; cmd_ch=0 with step=0 -> one STEP write of target.
REQ-038 rst asserted mid-WAIT -> all outputs at reset values without a clk edge; no writes thereafter.
